// File: rtl/rv32_1p_rf_wb.sv
// rv32_1p_rf_wb: write-side master for the single-port RV32 register file.
//   After reset it zero-fills every RF entry. It then buffers c5 write-back beats
//   in a small FIFO so they survive write-port stalls, and writes them to the RF
//   in acceptance order. It also flags c1 read addresses whose newest value is
//   not yet in the RF.
// Ports:
//   clk, rst                     clock; asynchronous active-high reset
//   wb_valid_c5/wb_ready_c5      write-back handshake (ready is combinational)
//   wb_addr_c5/wb_data_c5        write-back destination and data
//   rf_port_busy                 another master owns the RF write port this cycle
//   c_rf_wr/rd_addr_c6/rd_dati   registered RF write strobe, address and data
//   rs1/rs2_addr_c1, rs1/rs2_pend  read addresses and combinational pending flags
//   init_busy                    zero-fill in progress
//   fifo_level                   number of buffered beats
module rv32_1p_rf_wb #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned DEPTH   = 4,
  parameter bit          ZERO_X0 = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid_c5,
  output logic                       wb_ready_c5,
  input  logic [AW-1:0]              wb_addr_c5,
  input  logic [DW-1:0]              wb_data_c5,
  input  logic                       rf_port_busy,
  output logic                       c_rf_wr,
  output logic [AW-1:0]              rd_addr_c6,
  output logic [DW-1:0]              rd_dati,
  input  logic [AW-1:0]              rs1_addr_c1,
  input  logic [AW-1:0]              rs2_addr_c1,
  output logic                       rs1_pend,
  output logic                       rs2_pend,
  output logic                       init_busy,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic {S_INIT, S_RUN} state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_beat_t;

  state_e          state_q, state_d;
  logic [AW-1:0]   init_cnt_q, init_cnt_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  wb_beat_t        mem_q [DEPTH];
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   dati_q, dati_d;
  logic            push_c, pop_c, accept_c, keep_c;
  logic            hit1_c, hit2_c;

  assign wb_ready_c5 = (state_q == S_RUN) && (level_q < LW'(DEPTH));
  assign accept_c    = wb_valid_c5 && wb_ready_c5;
  // Beats to x0 are consumed but never written when ZERO_X0 is set.
  assign keep_c      = accept_c && !(ZERO_X0 && (wb_addr_c5 == '0));

  assign c_rf_wr    = wr_q;
  assign rd_addr_c6 = addr_q;
  assign rd_dati    = dati_q;
  assign init_busy  = (state_q == S_INIT);
  assign fifo_level = level_q;

  // Next-state and write-port selection.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    dati_d     = dati_q;
    push_c     = 1'b0;
    pop_c      = 1'b0;
    case (state_q)
      S_INIT: begin
        if (!rf_port_busy) begin
          wr_d       = 1'b1;
          addr_d     = init_cnt_q;
          dati_d     = '0;
          init_cnt_d = init_cnt_q + AW'(1);
          if (&init_cnt_q) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (rf_port_busy) begin
          push_c = keep_c;
        end else if (level_q != '0) begin
          pop_c  = 1'b1;
          wr_d   = 1'b1;
          addr_d = mem_q[rd_ptr_q].addr;
          dati_d = mem_q[rd_ptr_q].data;
          push_c = keep_c;
        end else if (keep_c) begin
          // Empty FIFO and free port: skip the buffer for single-cycle latency.
          wr_d   = 1'b1;
          addr_d = wb_addr_c5;
          dati_d = wb_data_c5;
        end
      end
      default: state_d = S_INIT;
    endcase
    level_d = LW'(level_q + LW'(push_c) - LW'(pop_c));
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      dati_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      level_q    <= level_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      dati_q     <= dati_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q].addr <= wb_addr_c5;
      mem_q[wr_ptr_q].data <= wb_data_c5;
    end
  end

  // Match read addresses against occupied FIFO slots (offset from head < level).
  always_comb begin
    hit1_c = 1'b0;
    hit2_c = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (LW'(PW'(PW'(i) - rd_ptr_q)) < level_q) begin
        if (mem_q[i].addr == rs1_addr_c1) hit1_c = 1'b1;
        if (mem_q[i].addr == rs2_addr_c1) hit2_c = 1'b1;
      end
    end
  end

  // The write in flight counts as pending: the RF returns old data on that edge.
  always_comb begin
    rs1_pend = init_busy || hit1_c || (wr_q && (addr_q == rs1_addr_c1));
    rs2_pend = init_busy || hit2_c || (wr_q && (addr_q == rs2_addr_c1));
    if (ZERO_X0 && !init_busy && (rs1_addr_c1 == '0)) rs1_pend = 1'b0;
    if (ZERO_X0 && !init_busy && (rs2_addr_c1 == '0)) rs2_pend = 1'b0;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push_c && (level_q == LW'(DEPTH))));

endmodule

// File: tb/tb_rv32_1p_rf_wb.sv
// Directed bench for rv32_1p_rf_wb: expected RF writes are queued when stimulus
// is driven and checked in order whenever the DUT strobes c_rf_wr.
module tb_rv32_1p_rf_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid_c5 = 1'b0;
  logic        wb_ready_c5;
  logic [7:0]  wb_addr_c5 = '0;
  logic [31:0] wb_data_c5 = '0;
  logic        rf_port_busy = 1'b0;
  logic        c_rf_wr;
  logic [7:0]  rd_addr_c6;
  logic [31:0] rd_dati;
  logic [7:0]  rs1_addr_c1 = '0;
  logic [7:0]  rs2_addr_c1 = '0;
  logic        rs1_pend, rs2_pend, init_busy;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q[$];

  rv32_1p_rf_wb #(.AW(8), .DW(32), .DEPTH(4), .ZERO_X0(1'b1)) dut (
    .clk(clk), .rst(rst),
    .wb_valid_c5(wb_valid_c5), .wb_ready_c5(wb_ready_c5),
    .wb_addr_c5(wb_addr_c5), .wb_data_c5(wb_data_c5),
    .rf_port_busy(rf_port_busy),
    .c_rf_wr(c_rf_wr), .rd_addr_c6(rd_addr_c6), .rd_dati(rd_dati),
    .rs1_addr_c1(rs1_addr_c1), .rs2_addr_c1(rs2_addr_c1),
    .rs1_pend(rs1_pend), .rs2_pend(rs2_pend),
    .init_busy(init_busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_init();
    for (int a = 0; a < 256; a++) exp_q.push_back({8'(a), 32'h0});
  endtask

  task automatic wait_init();
    for (int c = 0; c < 400; c++) begin
      step();
      if (!init_busy) break;
    end
    chk("init_done", 64'(init_busy), 64'(0));
    chk("init_last_wr", 64'(c_rf_wr), 64'(1));
    chk("init_last_addr", 64'(rd_addr_c6), 64'(255));
    chk("run_ready", 64'(wb_ready_c5), 64'(1));
  endtask

  // Scoreboard: every RF write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && c_rf_wr) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(rd_addr_c6), 64'(e[39:32]));
        chk("wr_data", 64'(rd_dati), 64'(e[31:0]));
      end
    end
  end

  initial begin
    int na;
    // Reset values
    step(2);
    chk("rst_wr", 64'(c_rf_wr), 64'(0));
    chk("rst_addr", 64'(rd_addr_c6), 64'(0));
    chk("rst_init_busy", 64'(init_busy), 64'(1));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_ready", 64'(wb_ready_c5), 64'(0));

    // 1. zero-fill of all 256 entries
    rst = 1'b0;
    expect_init();
    step();
    chk("init_first_addr", 64'(rd_addr_c6), 64'(0));
    chk("init_ready_low", 64'(wb_ready_c5), 64'(0));
    chk("init_pend", 64'(rs1_pend), 64'(1));
    wait_init();

    // 2. bypass with empty FIFO
    wb_valid_c5 = 1'b1; wb_addr_c5 = 8'd5; wb_data_c5 = 32'hDEADBEEF;
    exp_q.push_back({8'd5, 32'hDEADBEEF});
    step();
    wb_valid_c5 = 1'b0;
    chk("byp_wr", 64'(c_rf_wr), 64'(1));
    chk("byp_addr", 64'(rd_addr_c6), 64'(5));
    chk("byp_data", 64'(rd_dati), 64'hDEADBEEF);
    chk("byp_level", 64'(fifo_level), 64'(0));

    // 3. port busy fills the FIFO, then drains back-to-back
    rf_port_busy = 1'b1;
    na = 1;
    for (int i = 0; i < 6; i++) begin
      wb_valid_c5 = 1'b1; wb_addr_c5 = 8'(na); wb_data_c5 = 32'hA000_0000 | 32'(na);
      if (wb_ready_c5) begin
        exp_q.push_back({8'(na), 32'hA000_0000 | 32'(na)});
        na++;
      end
      step();
    end
    wb_valid_c5 = 1'b0;
    chk("full_level", 64'(fifo_level), 64'(4));
    chk("full_ready", 64'(wb_ready_c5), 64'(0));
    chk("full_wr", 64'(c_rf_wr), 64'(0));
    chk("full_accepted", 64'(na), 64'(5));
    rf_port_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_wr", 64'(c_rf_wr), 64'(1));
    end
    step();
    chk("drain_idle", 64'(c_rf_wr), 64'(0));
    chk("drain_level", 64'(fifo_level), 64'(0));

    // 4. write to x0 is accepted and dropped; x0 never pending
    wb_valid_c5 = 1'b1; wb_addr_c5 = 8'd0; wb_data_c5 = 32'h1234; rs1_addr_c1 = 8'd0;
    #1;
    chk("x0_ready", 64'(wb_ready_c5), 64'(1));
    chk("x0_pend", 64'(rs1_pend), 64'(0));
    step();
    wb_valid_c5 = 1'b0;
    chk("x0_no_wr", 64'(c_rf_wr), 64'(0));
    chk("x0_level", 64'(fifo_level), 64'(0));

    // 5. pending hazard while queued and during the write cycle
    rf_port_busy = 1'b1; rs1_addr_c1 = 8'd9; rs2_addr_c1 = 8'd7;
    wb_valid_c5 = 1'b1; wb_addr_c5 = 8'd7; wb_data_c5 = 32'h77;
    exp_q.push_back({8'd7, 32'h77});
    step();
    wb_valid_c5 = 1'b0;
    chk("hz_q_pend2", 64'(rs2_pend), 64'(1));
    chk("hz_q_pend1", 64'(rs1_pend), 64'(0));
    chk("hz_q_level", 64'(fifo_level), 64'(1));
    step();
    chk("hz_q2_pend2", 64'(rs2_pend), 64'(1));
    rf_port_busy = 1'b0;
    step();
    chk("hz_wr", 64'(c_rf_wr), 64'(1));
    chk("hz_wr_addr", 64'(rd_addr_c6), 64'(7));
    chk("hz_wr_pend2", 64'(rs2_pend), 64'(1));
    step();
    chk("hz_after_wr", 64'(c_rf_wr), 64'(0));
    chk("hz_after_pend2", 64'(rs2_pend), 64'(0));

    // 6. reset mid-operation discards queued beats, then INIT restarts at 0
    rf_port_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_valid_c5 = 1'b1; wb_addr_c5 = 8'(10 + i); wb_data_c5 = 32'(100 + i);
      step();
    end
    wb_valid_c5 = 1'b0;
    chk("pre_rst_level", 64'(fifo_level), 64'(3));
    rf_port_busy = 1'b0;
    step();
    chk("pre_rst_wr", 64'(c_rf_wr), 64'(1));
    chk("pre_rst_addr", 64'(rd_addr_c6), 64'(10));
    chk("pre_rst_level2", 64'(fifo_level), 64'(2));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wr", 64'(c_rf_wr), 64'(0));
    chk("mid_rst_level", 64'(fifo_level), 64'(0));
    chk("mid_rst_init", 64'(init_busy), 64'(1));
    step();
    rst = 1'b0;
    expect_init();
    step();
    chk("reinit_first", 64'(rd_addr_c6), 64'(0));
    wait_init();
    step(2);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
